param_memory: RTL
=================

PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter DATA_W, default 16, SHALL set the word width in bits and SHALL be a multiple of 8.
REQ-003 Parameter ADDR_W, default 8, SHALL set the address width; depth SHALL be 2**ADDR_W words.
REQ-004 Parameter BE_W, derived as DATA_W/8, SHALL set the byte-enable width.
REQ-005 Port CLK  input  1  SHALL be the rising-edge clock.
REQ-006 Port RST  input  1  SHALL be the asynchronous active-high reset.
REQ-007 Port REQ  input  1  SHALL be the access request, qualified by RDY.
REQ-008 Port WE  input  1  SHALL select write (1) or read (0) for the request.
REQ-009 Port ADDR  input  ADDR_W  SHALL be the word address.
REQ-010 Port WD  input  DATA_W  SHALL be the write data.
REQ-011 Port BE  input  BE_W  SHALL be the byte enables; bit i SHALL gate WD[8i+7:8i].
REQ-012 Port CLR  input  1  SHALL request a full-array clear.
REQ-013 Port RDY  output  1  SHALL indicate the block accepts a request this cycle.
REQ-014 Port RVALID  output  1  SHALL be a one-cycle pulse marking valid RD.
REQ-015 Port RD  output  DATA_W  SHALL be the registered read data.
REQ-016 Port BUSY  output  1  SHALL indicate a clear sequence in progress.

Function
REQ-017 States SHALL be IDLE and CLEAR; RDY SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted on a rising edge with REQ=1 and RDY=1; otherwise REQ SHALL be ignored without side effect.
REQ-019 An accepted write SHALL update only the bytes with BE=1 at ADDR on that edge; BE=0 SHALL leave the word unchanged.
REQ-020 An accepted read SHALL drive RD with the word at ADDR and RVALID=1 on the next edge (latency 1); RD SHALL hold its value while RVALID=0.
REQ-021 An accepted write SHALL NOT assert RVALID nor change RD.
REQ-022 Back-to-back reads SHALL be sustained one per cycle; a read of an address written on the previous cycle SHALL return the new data.
REQ-023 CLR=1 in IDLE SHALL move the state to CLEAR on the next edge, taking priority over a simultaneous REQ, which SHALL be dropped.
REQ-024 In CLEAR, a counter SHALL write all-zero to address 0, 1, ... 2**ADDR_W-1, one word per cycle, then return to IDLE; the clear SHALL take exactly 2**ADDR_W cycles with BUSY=1.
REQ-025 CLR asserted during CLEAR SHALL be ignored and SHALL NOT restart the counter.
REQ-026 The clear counter SHALL be ADDR_W+1 bits wide, with no wrap before completion.

Reset
REQ-027 While RST=1: RDY=0, RVALID=0, RD=0, BUSY=0, clear counter=0; array contents SHALL NOT be reset.
REQ-028 After RST falls, the first edge SHALL enter CLEAR (BUSY=1) when the clear feature is compiled in, else IDLE.
REQ-029 RST during CLEAR SHALL abort the sequence; the post-reset clear SHALL restart at address 0.

Configuration
REQ-030 Macro PARAM_MEMORY_CLR_EN SHALL compile in the CLEAR state, counter, CLR input behaviour and post-reset clear.
REQ-031 Without PARAM_MEMORY_CLR_EN: CLR SHALL be ignored, BUSY SHALL be tied 0, the block SHALL stay in IDLE, and array contents after reset SHALL be undefined.

Structure
REQ-032 Package param_memory_pkg SHALL hold the state enum type and the DATA_W/ADDR_W default constants.
REQ-033 Sub-module param_memory_array SHALL hold the storage with a synchronous byte-enabled write port and a registered read port; the FSM, counter and handshake SHALL stay in param_memory.

Verification
REQ-034 Reset, then release with CLR_EN -> BUSY=1 for exactly 256 cycles, RDY=1 on the next cycle, reads of addresses 0x00 and 0xFF return 0x0000.
REQ-035 Write 0xA5C3 to 0x10 with BE=11, then read 0x10 -> RD=0xA5C3 with RVALID one cycle after acceptance; write 0xFF00 with BE=01, then read -> 0xA500.
REQ-036 REQ=1 and CLR=1 on the same IDLE cycle -> no write occurs, CLEAR entered, the word at the target address reads 0x0000 afterwards.
REQ-037 Assert RST at clear counter=100, release -> clear restarts at 0, BUSY high for 256 cycles, and no access is accepted meanwhile.
REQ-038 Reads of 0x01, 0x02, 0x03 on consecutive cycles -> three consecutive RVALID pulses carrying the matching data; without CLR_EN -> BUSY=0 throughout and RDY=1 on the first cycle after reset.

Source files
------------

// File: rtl/param_memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : param_memory_pkg
//  Description : Shared types and default sizing for the param_memory block.
//                Holds the controller state enum and the default word and
//                address widths used by param_memory and param_memory_array.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package param_memory_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/param_memory_array.sv
`default_nettype none
// ============================================================================
//  Module      : param_memory_array
//  Description : 2**ADDR_W x DATA_W storage with one shared address, a
//                synchronous byte-enabled write and a registered read port.
//                Storage is never reset; only the read register is.
//  Ports       : clk, rst        - clock, async active-high reset (read reg)
//                i_we, i_be      - write strobe and per-byte enables
//                i_re            - read strobe (loads o_rd on the edge)
//                i_addr, i_wd    - word address and write data
//                o_rd            - registered read data, holds between reads
//  Revision    : 1.0 - initial release
// ============================================================================
module param_memory_array #(
  parameter  int DATA_W = 16,
  parameter  int ADDR_W = 8,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [BE_W-1:0]   i_be,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wd,
  output logic [DATA_W-1:0] o_rd
);

  localparam int c_depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [0:c_depth-1];
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] rd_d;

  // Storage has no reset so it can map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (i_be[i]) begin
          mem_q[i_addr][8*i +: 8] <= i_wd[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_d = rd_q;
    if (i_re) begin
      rd_d = mem_q[i_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign o_rd = rd_q;

endmodule
`default_nettype wire

// File: rtl/param_memory.sv
`default_nettype none
// ============================================================================
//  Module      : param_memory
//  Description : Single-port parameterised memory with REQ/RDY handshake,
//                byte-enabled writes, latency-1 registered reads and an
//                optional full-array clear sequencer.
//  Config      : define PARAM_MEMORY_CLR_EN to build the CLEAR state, the
//                clear counter, the CLR input and the post-reset clear.
//                Without it CLR is ignored, BUSY is 0 and contents after
//                reset are undefined.
//  Ports       : CLK, RST   - clock, async active-high reset
//                REQ, WE    - request (taken when RDY=1), write/read select
//                ADDR, WD   - word address, write data
//                BE         - byte enables, BE[i] gates WD[8i+7:8i]
//                CLR        - request a full-array clear
//                RDY        - request accepted this cycle
//                RVALID, RD - one-cycle read-valid pulse, registered data
//                BUSY       - clear sequence in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module param_memory
  import param_memory_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int ADDR_W = ADDR_W_DEF,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WD,
  input  logic [BE_W-1:0]   BE,
  input  logic              CLR,
  output logic              RDY,
  output logic              RVALID,
  output logic [DATA_W-1:0] RD,
  output logic              BUSY
);

  state_t            state_q, state_d;
  logic              run_q;      // 0 from reset until the first clock edge
  logic              rvalid_q, rvalid_d;
  logic              w_clr_take; // CLR wins over REQ in IDLE
  logic              w_clearing;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_acc_rd, w_acc_wr;

`ifdef PARAM_MEMORY_CLR_EN
  // Extra bit lets the counter reach DEPTH without wrapping to 0.
  localparam logic [ADDR_W:0] c_depth = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [ADDR_W:0] w_cnt_inc;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_cnt_inc = cnt_q + 1'b1;
    if (!run_q) begin
      // First edge after reset always starts a clear from address 0.
      state_d = ST_CLEAR;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (CLR) state_d = ST_CLEAR;
        end
        ST_CLEAR: begin
          // CLR is not looked at here, so it cannot restart the sweep.
          if (w_cnt_inc == c_depth) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = w_cnt_inc;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign w_clr_take = CLR;
  assign w_clearing = (state_q == ST_CLEAR);
  assign w_clr_addr = cnt_q[ADDR_W-1:0];
`else
  logic w_unused_clr;

  always_comb begin
    state_d = ST_IDLE;
  end

  assign w_unused_clr = CLR;
  assign w_clr_take   = 1'b0;
  assign w_clearing   = 1'b0;
  assign w_clr_addr   = '0;
`endif

  assign RDY      = run_q && (state_q == ST_IDLE);
  assign w_acc_rd = REQ && RDY && !w_clr_take && !WE;
  assign w_acc_wr = REQ && RDY && !w_clr_take &&  WE;

  always_comb begin
    rvalid_d = w_acc_rd;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      run_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= 1'b1;
      rvalid_q <= rvalid_d;
    end
  end

  // During a clear the counter owns the port and writes full zero words.
  param_memory_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk    (CLK),
    .rst    (RST),
    .i_we   (w_clearing || w_acc_wr),
    .i_be   (w_clearing ? {BE_W{1'b1}} : BE),
    .i_re   (w_acc_rd),
    .i_addr (w_clearing ? w_clr_addr : ADDR),
    .i_wd   (w_clearing ? {DATA_W{1'b0}} : WD),
    .o_rd   (RD)
  );

  assign RVALID = rvalid_q;
  assign BUSY   = w_clearing;

endmodule
`default_nettype wire
